// File: rtl/merge_sched.sv
// Two-way stable merge of sorted runs held in FWFT FIFOs A and B.
// Emits the merged stream through a registered write port into an output FIFO.
module merge_sched #(
  parameter int unsigned COLUMN = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      run_len,
  input  logic [1:0]            sort_col,
  input  logic [8*COLUMN-1:0]   a_data,
  input  logic [8*COLUMN-1:0]   b_data,
  input  logic                  a_empty,
  input  logic                  b_empty,
  output logic                  a_rd,
  output logic                  b_rd,
  input  logic                  out_afull,
  output logic                  out_wr,
  output logic [8*COLUMN-1:0]   out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    DRAIN_A,
    DRAIN_B,
    FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]      cnt_b_q, cnt_b_d;
  logic [1:0]            col_q, col_d;
  logic                  out_wr_q, out_wr_d;
  logic [8*COLUMN-1:0]   out_data_q, out_data_d;
  logic [7:0]            key_a, key_b;

  // col_q is already clamped below COLUMN when it is latched
  always_comb begin
    key_a = a_data[7:0];
    key_b = b_data[7:0];
    for (int unsigned i = 1; i < COLUMN; i++) begin
      if (32'(col_q) == i) begin
        key_a = a_data[8*i +: 8];
        key_b = b_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    col_d   = col_q;
    a_rd    = 1'b0;
    b_rd    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_a_d = run_len;
          cnt_b_d = run_len;
          col_d   = (32'(sort_col) < COLUMN) ? sort_col : 2'd0;
          state_d = (run_len == '0) ? FINISH : MERGE;
        end
      end
      MERGE: begin
        if (!out_afull && !a_empty && !b_empty) begin
          if (key_a <= key_b) a_rd = 1'b1;
          else                b_rd = 1'b1;
        end
      end
      DRAIN_A: a_rd = !out_afull && !a_empty;
      DRAIN_B: b_rd = !out_afull && !b_empty;
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counts are nonzero in every popping state; the guard keeps them from wrapping.
    if (a_rd && cnt_a_q != '0) begin
      cnt_a_d = cnt_a_q - CNT_W'(1);
      if (cnt_a_q == CNT_W'(1)) state_d = (state_q == MERGE) ? DRAIN_B : FINISH;
    end
    if (b_rd && cnt_b_q != '0) begin
      cnt_b_d = cnt_b_q - CNT_W'(1);
      if (cnt_b_q == CNT_W'(1)) state_d = (state_q == MERGE) ? DRAIN_A : FINISH;
    end

    out_wr_d   = a_rd | b_rd;
    out_data_d = a_rd ? a_data : (b_rd ? b_data : out_data_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      col_q      <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      col_q      <= col_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;

endmodule
